// File: rtl/matmul_pkg.sv
// Shared defaults, derived bus sizes and packing helpers for the matrix-multiply core.
package matmul_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ACC_WIDTH  = 16;
  localparam int unsigned DEF_ROW_LEN1   = 3;
  localparam int unsigned DEF_COL_LEN1   = 3;
  localparam int unsigned DEF_ROW_LEN2   = 3;
  localparam int unsigned DEF_COL_LEN2   = 3;

  localparam int unsigned MAT1_SIZE   = DEF_ROW_LEN1 * DEF_COL_LEN1 * DEF_DATA_WIDTH;
  localparam int unsigned MAT2_SIZE   = DEF_ROW_LEN2 * DEF_COL_LEN2 * DEF_DATA_WIDTH;
  localparam int unsigned RESULT_SIZE = DEF_ROW_LEN1 * DEF_COL_LEN2 * DEF_ACC_WIDTH;

  function automatic int unsigned elem_idx(int unsigned row, int unsigned col,
                                           int unsigned ncols);
    return row * ncols + col;
  endfunction

  // Row-major packing with element (0,0) in the MSBs.
  function automatic int unsigned elem_lsb(int unsigned size, int unsigned row,
                                           int unsigned col, int unsigned ncols,
                                           int unsigned width);
    return size - (elem_idx(row, col, ncols) + 1) * width;
  endfunction

endpackage

// File: rtl/matmul_dot.sv
// Combinational unsigned dot product reduced to ACC_WIDTH.
// Clamps instead of truncating when MATMUL_SATURATE_EN is defined.
module matmul_dot
  import matmul_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int unsigned LEN        = DEF_COL_LEN1
) (
  input  logic [LEN*DATA_WIDTH-1:0] a_row,
  input  logic [LEN*DATA_WIDTH-1:0] b_col,
  output logic [ACC_WIDTH-1:0]      dot
);

  localparam int unsigned SUM_W = 2 * DATA_WIDTH + $clog2(LEN + 1);

  logic [SUM_W-1:0] sum;

  always_comb begin
    sum = '0;
    for (int k = 0; k < int'(LEN); k++) begin
      sum = sum + SUM_W'(a_row[(int'(LEN) - 1 - k) * int'(DATA_WIDTH) +: DATA_WIDTH])
                * SUM_W'(b_col[(int'(LEN) - 1 - k) * int'(DATA_WIDTH) +: DATA_WIDTH]);
    end
  end

  if (SUM_W > ACC_WIDTH) begin : g_reduce
`ifdef MATMUL_SATURATE_EN
    assign dot = (|sum[SUM_W-1:ACC_WIDTH]) ? '1 : sum[ACC_WIDTH-1:0];
`else
    logic unused_hi;
    assign unused_hi = ^sum[SUM_W-1:ACC_WIDTH];
    assign dot = sum[ACC_WIDTH-1:0];
`endif
  end else begin : g_widen
    assign dot = ACC_WIDTH'(sum);
  end

endmodule

// File: rtl/matmul_unit.sv
// Two-stage pipelined C = A x B with all dot products in parallel.
// Optional MATMUL_SATURATE_EN clamps overflowing elements to all-ones.
module matmul_unit
  import matmul_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int unsigned ROW_LEN1   = DEF_ROW_LEN1,
  parameter int unsigned COL_LEN1   = DEF_COL_LEN1,
  parameter int unsigned ROW_LEN2   = DEF_ROW_LEN2,
  parameter int unsigned COL_LEN2   = DEF_COL_LEN2
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic [ROW_LEN1*COL_LEN1*DATA_WIDTH-1:0]   Mat1_in,
  input  logic [ROW_LEN2*COL_LEN2*DATA_WIDTH-1:0]   Mat2_in,
  output logic [ROW_LEN1*COL_LEN2*ACC_WIDTH-1:0]    result,
  output logic                                      result_valid
);

  localparam int unsigned M1_W  = ROW_LEN1 * COL_LEN1 * DATA_WIDTH;
  localparam int unsigned M2_W  = ROW_LEN2 * COL_LEN2 * DATA_WIDTH;
  localparam int unsigned RES_W = ROW_LEN1 * COL_LEN2 * ACC_WIDTH;

  if (COL_LEN1 != ROW_LEN2) begin : g_bad_dims
    $error("matmul_unit: COL_LEN1 must equal ROW_LEN2");
  end

  logic [M1_W-1:0]  op1_q;
  logic [M2_W-1:0]  op2_q;
  logic             s1_valid_q;
  logic [RES_W-1:0] result_d;
  logic [RES_W-1:0] result_q;
  logic             result_valid_q;

  for (genvar r = 0; r < ROW_LEN1; r++) begin : g_row
    for (genvar c = 0; c < COL_LEN2; c++) begin : g_col
      logic [COL_LEN1*DATA_WIDTH-1:0] a_row;
      logic [COL_LEN1*DATA_WIDTH-1:0] b_col;

      // A rows are contiguous; B columns are gathered element by element.
      assign a_row = op1_q[elem_lsb(M1_W, r, COL_LEN1 - 1, COL_LEN1, DATA_WIDTH)
                           +: COL_LEN1*DATA_WIDTH];
      for (genvar k = 0; k < COL_LEN1; k++) begin : g_k
        assign b_col[(COL_LEN1-1-k)*DATA_WIDTH +: DATA_WIDTH] =
            op2_q[elem_lsb(M2_W, k, c, COL_LEN2, DATA_WIDTH) +: DATA_WIDTH];
      end

      matmul_dot #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .LEN       (COL_LEN1)
      ) u_dot (
        .a_row(a_row),
        .b_col(b_col),
        .dot  (result_d[elem_lsb(RES_W, r, c, COL_LEN2, ACC_WIDTH) +: ACC_WIDTH])
      );
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op1_q          <= '0;
      op2_q          <= '0;
      s1_valid_q     <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      if (start) begin
        op1_q <= Mat1_in;
        op2_q <= Mat2_in;
      end
      s1_valid_q <= start;
      if (s1_valid_q) begin
        result_q <= result_d;
      end
      result_valid_q <= s1_valid_q;
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_matmul_unit.sv
// Directed-vector bench for matmul_unit (3x3, 8-bit operands, 16-bit results).
module tb_matmul_unit;

  logic         clk;
  logic         reset;
  logic         start;
  logic [71:0]  mat1;
  logic [71:0]  mat2;
  logic [143:0] result;
  logic         result_valid;

  int checks;
  int failures;

  matmul_unit u_dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .Mat1_in     (mat1),
    .Mat2_in     (mat2),
    .result      (result),
    .result_valid(result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [71:0]  a;
    logic [71:0]  b;
    logic [143:0] exp;
  } vec_t;

  vec_t vecs[6];

  localparam logic [71:0]  IdentB    = 72'h010000_000100_000001;
  localparam logic [143:0] BasicExp  =
      144'h016d_00ea_0272_0015_0066_0048_0164_0250_02e5;
`ifdef MATMUL_SATURATE_EN
  localparam logic [143:0] OvfExp    = {9{16'hffff}};
`else
  localparam logic [143:0] OvfExp    = {9{16'hfa03}};
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_res(input string name, input logic [143:0] exp);
    checks++;
    if (result !== exp) begin
      failures++;
      $display("FAIL %s: result=%h expected=%h", name, result, exp);
    end
  endtask

  task automatic check_vld(input string name, input logic exp);
    checks++;
    if (result_valid !== exp) begin
      failures++;
      $display("FAIL %s: result_valid=%b expected=%b", name, result_valid, exp);
    end
  endtask

  initial begin
    logic [143:0] prev_exp;
    logic [143:0] id_exp;
    logic         pat[8];

    checks   = 0;
    failures = 0;

    vecs[0] = '{"live_update", 72'h0a1102_050100_1c1005, 72'h000a08_150220_040001,
                144'h016d_0086_0272_0015_0034_0048_0164_0138_02e5};
    vecs[1] = '{"overflow", {9{8'hff}}, {9{8'hff}}, OvfExp};
    vecs[2] = '{"zeros", 72'h0, 72'h001408_150220_040001, 144'h0};
    vecs[3] = '{"identity_a", IdentB, 72'h001408_150220_040001,
                144'h0000_0014_0008_0015_0002_0020_0004_0000_0001};
    vecs[4] = '{"all_ones", {9{8'h01}}, {9{8'h01}}, {9{16'h0003}}};
    vecs[5] = '{"exact_max", {3{24'hffff00}}, 72'hffffff_020202_000000, {9{16'hffff}}};

    // Reset held with live stimulus
    reset = 1'b0;
    start = 1'b1;
    mat1  = {$urandom(), $urandom(), 8'($urandom())};
    mat2  = {$urandom(), $urandom(), 8'($urandom())};
    repeat (3) step();
    check_res("reset_result", 144'h0);
    check_vld("reset_valid", 1'b0);

    // First product after release: valid two edges after start is sampled
    reset = 1'b1;
    start = 1'b0;
    step();
    start = 1'b1;
    mat1  = 72'h0a1102_050100_1c1005;
    mat2  = 72'h001408_150220_040001;
    step();
    check_vld("latency_edge1_valid", 1'b0);
    check_res("latency_edge1_result", 144'h0);
    step();
    check_vld("basic_valid", 1'b1);
    check_res("basic_result", BasicExp);
    prev_exp = BasicExp;

    // Continuous tracking: one edge shows the previous product, the next shows the new one
    for (int i = 0; i < 6; i++) begin
      mat1 = vecs[i].a;
      mat2 = vecs[i].b;
      step();
      check_res({vecs[i].name, "_mid"}, prev_exp);
      step();
      check_res(vecs[i].name, vecs[i].exp);
      check_vld({vecs[i].name, "_valid"}, 1'b1);
      prev_exp = vecs[i].exp;
    end

    // Hold: drop start then scramble operands
    start = 1'b0;
    step();
    mat1 = 72'h0a1102_050100_1c1005;
    mat2 = 72'h001408_150220_040001;
    check_vld("hold_edge1_valid", 1'b1);
    check_res("hold_edge1_result", prev_exp);
    step();
    check_vld("hold_edge2_valid", 1'b0);
    check_res("hold_edge2_result", prev_exp);
    repeat (2) step();
    check_res("hold_late_result", prev_exp);

    // Toggling start: result_valid is start delayed two edges
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      start = pat[i];
      step();
      if (i >= 1) check_vld($sformatf("toggle_%0d", i), pat[i-1]);
    end
    start = 1'b0;
    step();
    check_vld("toggle_tail", 1'b0);
    check_res("toggle_result", BasicExp);

    // Asynchronous reset between edges
    start = 1'b1;
    mat1  = {9{8'h01}};
    mat2  = {9{8'h01}};
    repeat (2) step();
    check_res("pre_async_result", {9{16'h0003}});
    #2 reset = 1'b0;
    #1;
    check_res("async_reset_result", 144'h0);
    check_vld("async_reset_valid", 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Identity B: result is A zero-extended per element
    mat2 = IdentB;
    for (int n = 0; n < 100; n++) begin
      mat1 = {$urandom(), $urandom(), 8'($urandom())};
      for (int e = 0; e < 9; e++) begin
        id_exp[143 - e*16 -: 16] = {8'h00, mat1[71 - e*8 -: 8]};
      end
      repeat (2) step();
      check_res($sformatf("identity_%0d", n), id_exp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
